imem_loader: RTL

- Boot-time writer for the CPU's read-only instruction memory.
- Receives a byte stream over a valid/ready handshake, assembles 32-bit little-endian instruction words and writes them to consecutive word addresses starting at BASE_ADDR.
- Holds the CPU in reset until the whole program has been written, then releases it.
- Sits between the host/debug byte source and the instruction-memory write port; its cpu_reset output drives the PC reset.

---
 rtl/imem_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the CPU instruction memory.
//
// Accepts a byte stream over a valid/ready handshake. The stream starts with
// a 16-bit little-endian word count N, followed by 4*N payload bytes. The
// payload is packed into 32-bit little-endian words, and each word is written
// to consecutive word addresses starting at BASE_ADDR. The CPU is held in
// reset until all N words have been written.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   byte_valid  source presents a byte on byte_data
//   byte_data   stream byte
//   byte_ready  loader can accept a byte this cycle
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   byte address of the write (word aligned)
//   imem_wdata  instruction word to write
//   cpu_reset   active-high reset to the PC/CPU
//   done        program fully loaded
//   error       header rejected (N==0 or N>DEPTH_WORDS)
module imem_loader #(
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_n;
  logic [15:0] r_widx;
  logic [1:0]  r_bidx;
  logic [31:0] r_asm;
  logic        r_we;
  logic [63:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_accept;
  logic [15:0] w_n_full;
  logic        w_n_bad;
  logic [15:0] w_widx_inc;
  logic [31:0] w_asm_next;

  assign byte_ready = (r_state == S_IDLE) || (r_state == S_HDR_HI) ||
                      (r_state == S_DATA);
  assign w_accept   = byte_valid && byte_ready;

  // Header word count as it will be once the high byte lands on this edge.
  assign w_n_full   = {byte_data, r_n[7:0]};
  assign w_n_bad    = (w_n_full == 16'd0) ||
                      ({16'd0, w_n_full} > DEPTH_WORDS);
  assign w_widx_inc = r_widx + 16'd1;

  always_comb begin
    w_asm_next = r_asm;
    case (r_bidx)
      2'd0:    w_asm_next[7:0]   = byte_data;
      2'd1:    w_asm_next[15:8]  = byte_data;
      2'd2:    w_asm_next[23:16] = byte_data;
      default: w_asm_next[31:24] = byte_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_widx  <= '0;
      r_bidx  <= '0;
      r_asm   <= '0;
      r_we    <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_n[7:0] <= byte_data;
            r_state  <= S_HDR_HI;
          end
        end
        S_HDR_HI: begin
          if (w_accept) begin
            r_n[15:8] <= byte_data;
            r_bidx    <= '0;
            r_state   <= w_n_bad ? S_ERR : S_DATA;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_asm  <= w_asm_next;
            r_bidx <= r_bidx + 2'd1;
            if (r_bidx == 2'd3) begin
              // Outputs are registered here so they are valid throughout WRITE.
              r_we    <= 1'b1;
              r_wdata <= w_asm_next;
              r_addr  <= BASE_ADDR + {46'd0, r_widx, 2'b00};
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_widx  <= w_widx_inc;
          r_bidx  <= '0;
          r_state <= (w_widx_inc == r_n) ? S_DONE : S_DATA;
        end
        S_DONE:  r_state <= S_DONE;
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_reset  = (r_state != S_DONE);
  assign done       = (r_state == S_DONE);
  assign error      = (r_state == S_ERR);

endmodule
